// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder.
//   state_e        : controller state, 1-bit encoding (IDLE, RUN)
//   WIDTH_DEFAULT  : default operand/sum width
package serial_adder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int WIDTH_DEFAULT = 8;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_full_add.sv
// Single-bit adder cells for the bit-serial adder datapath.
// half_add ports:
//   a, b  in  : addend bits
//   sum   out : a ^ b
//   cout  out : a & b
// full_add ports:
//   a, b, cin in  : addend bits and carry-in
//   sum       out : a ^ b ^ cin
//   cout      out : carry-out
// full_add is built from two half_add cells and an OR; purely combinational.
module half_add (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b;
    assign cout = a & b;

endmodule : half_add

module full_add (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic s0;
    logic c0;
    logic c1;

    half_add u_ha0 (
        .a    (a),
        .b    (b),
        .sum  (s0),
        .cout (c0)
    );

    half_add u_ha1 (
        .a    (s0),
        .b    (cin),
        .sum  (sum),
        .cout (c1)
    );

    // Both half-adder carries can never be high together, so OR is exact.
    assign cout = c0 | c1;

endmodule : full_add

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder. Operands and carry-in are captured on an
// accepted start, then added LSB-first through one full-adder cell and a
// carry flip-flop, one bit per clock. After WIDTH RUN cycles the result is
// loaded into the output registers and done pulses for one cycle.
// Ports:
//   clk    in  1      clock, rising edge
//   rst    in  1      synchronous active-high reset
//   start  in  1      request, only sampled while idle
//   a, b   in  WIDTH  operands, captured on accepted start
//   cin    in  1      carry-in, captured on accepted start
//   busy   out 1      addition in progress
//   done   out 1      one-cycle pulse, sum/cout just updated
//   sum    out WIDTH  result, held until next completion
//   cout   out 1      carry-out, held until next completion
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] s_sr_q, s_sr_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             done_q, done_d;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] s_shift;

    full_add u_fa (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (carry_q),
        .sum  (fa_s),
        .cout (fa_c)
    );

    // New sum bit enters at the MSB; after WIDTH shifts the first bit
    // computed has reached bit 0. Written as shift-then-overwrite so that
    // WIDTH=1 needs no special-cased slice.
    always_comb begin
        s_shift            = s_sr_q >> 1;
        s_shift[WIDTH-1]   = fa_s;
    end

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        s_sr_d  = s_sr_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = cin;
                    s_sr_d  = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                s_sr_d  = s_shift;
                carry_d = fa_c;
                cnt_d   = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    sum_d   = s_shift;
                    cout_d  = fa_c;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            s_sr_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            s_sr_q  <= s_sr_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
        end
    end

    // busy is decoded from the registered state, so it drops on the same
    // edge that raises done and the two are never high together.
    assign busy = (state_q == RUN);
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        s8, s1, s32;
    logic [7:0]  a8, b8;
    logic [0:0]  a1, b1;
    logic [31:0] a32, b32;
    logic        c8, c1, c32;
    logic        busy8, busy1, busy32;
    logic        done8, done1, done32;
    logic [7:0]  sum8;
    logic [0:0]  sum1;
    logic [31:0] sum32;
    logic        cout8, cout1, cout32;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [32:0] sb[$];

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8), .cin(c8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );
    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(s1), .a(a1), .b(b1), .cin(c1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );
    serial_adder #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(s32), .a(a32), .b(b32), .cin(c32),
        .busy(busy32), .done(done32), .sum(sum32), .cout(cout32)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive one start on the WIDTH=8 instance, then wait (bounded) for done.
    // lat = edges from acceptance to done, or -1 on timeout.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       output int lat, output logic [8:0] got);
        s8 = 1'b1; a8 = a; b8 = b; c8 = c;
        sb.push_back(33'(a) + 33'(b) + 33'(c));
        tick;
        s8 = 1'b0; a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 20) begin
            tick;
            lat++;
        end
        if (!done8) lat = -1;
        got = {cout8, sum8};
    endtask

    function automatic logic get_done(input int w);
        case (w)
            1:       return done1;
            8:       return done8;
            default: return done32;
        endcase
    endfunction

    function automatic logic get_busy(input int w);
        case (w)
            1:       return busy1;
            8:       return busy8;
            default: return busy32;
        endcase
    endfunction

    function automatic logic [32:0] get_res(input int w);
        case (w)
            1:       return 33'({cout1, sum1});
            8:       return 33'({cout8, sum8});
            default: return 33'({cout32, sum32});
        endcase
    endfunction

    task automatic set_in(input int w, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input logic c);
        case (w)
            1:       begin s1 = s;  a1 = a[0:0]; b1 = b[0:0]; c1 = c;  end
            8:       begin s8 = s;  a8 = a[7:0]; b8 = b[7:0]; c8 = c;  end
            default: begin s32 = s; a32 = a;     b32 = b;     c32 = c; end
        endcase
    endtask

    task automatic test_reset;
        rst = 1'b1;
        s8 = 0; s1 = 0; s32 = 0;
        a8 = 0; b8 = 0; c8 = 0; a1 = 0; b1 = 0; c1 = 0; a32 = 0; b32 = 0; c32 = 0;
        tick;
        tick;
        rst = 1'b0;
        total_cnt++;
        if (busy8 !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy8);
        else pass_cnt++;
        total_cnt++;
        if (done8 !== 1'b0) $display("FAIL reset_done: got %b want 0", done8);
        else pass_cnt++;
        total_cnt++;
        if ({cout8, sum8} !== 9'h000) $display("FAIL reset_result: got %h want 000", {cout8, sum8});
        else pass_cnt++;
        total_cnt++;
        if ({busy1, busy32, done1, done32} !== 4'b0000)
            $display("FAIL reset_other: got %b want 0000", {busy1, busy32, done1, done32});
        else pass_cnt++;
    endtask

    task automatic test_basic;
        int lat;
        logic [32:0] exp;
        s8 = 1'b1; a8 = 8'h0F; b8 = 8'h01; c8 = 1'b0;
        sb.push_back(33'h0_0000_0010);
        tick;
        s8 = 1'b0;
        total_cnt++;
        if (busy8 !== 1'b1 || sum8 !== 8'h00)
            $display("FAIL basic_busy: got busy=%b sum=%h want busy=1 sum=00", busy8, sum8);
        else pass_cnt++;
        lat = 1;
        tick;
        while (!done8 && lat < 20) begin
            tick;
            lat++;
        end
        exp = sb.pop_front();
        total_cnt++;
        if (lat !== 8) $display("FAIL basic_latency: got %0d want 8", lat);
        else pass_cnt++;
        total_cnt++;
        if (33'({cout8, sum8}) !== exp) $display("FAIL basic_sum: got %h want %h", {cout8, sum8}, exp);
        else pass_cnt++;
    endtask

    task automatic test_carry;
        int lat;
        logic [8:0] got;
        logic [32:0] exp;
        op8(8'hFF, 8'h01, 1'b0, lat, got);
        exp = sb.pop_front();
        total_cnt++;
        if (33'(got) !== exp || lat !== 8)
            $display("FAIL carry_out: got %h lat %0d want %h lat 8", got, lat, exp);
        else pass_cnt++;
        op8(8'h00, 8'h00, 1'b1, lat, got);
        exp = sb.pop_front();
        total_cnt++;
        if (33'(got) !== exp || lat !== 8)
            $display("FAIL carry_in: got %h lat %0d want %h lat 8", got, lat, exp);
        else pass_cnt++;
    endtask

    task automatic test_ignore;
        int lat;
        logic [32:0] exp;
        s8 = 1'b1; a8 = 8'hA5; b8 = 8'h5A; c8 = 1'b1;
        sb.push_back(33'(8'hA5) + 33'(8'h5A) + 33'd1);
        tick;
        s8 = 1'b0; a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
        tick; tick; tick;
        s8 = 1'b1; a8 = 8'h11; b8 = 8'h22; c8 = 1'b0;
        tick;
        s8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        lat = 4;
        while (!done8 && lat < 20) begin
            tick;
            lat++;
        end
        exp = sb.pop_front();
        total_cnt++;
        if (33'({cout8, sum8}) !== exp || lat !== 8)
            $display("FAIL ignore_sum: got %h lat %0d want %h lat 8", {cout8, sum8}, lat, exp);
        else pass_cnt++;
        tick;
        total_cnt++;
        if (done8 !== 1'b0 || busy8 !== 1'b0)
            $display("FAIL ignore_after: got done=%b busy=%b want 0 0", done8, busy8);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int lat;
        logic seen;
        logic [8:0] got;
        logic [32:0] exp;
        s8 = 1'b1; a8 = 8'h12; b8 = 8'h34; c8 = 1'b1;
        tick;
        s8 = 1'b0;
        tick; tick; tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        total_cnt++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || {cout8, sum8} !== 9'h000)
            $display("FAIL midreset_state: got busy=%b done=%b res=%h want 0 0 000",
                     busy8, done8, {cout8, sum8});
        else pass_cnt++;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (done8 || busy8) seen = 1'b1;
        end
        total_cnt++;
        if (seen !== 1'b0) $display("FAIL midreset_quiet: got activity=%b want 0", seen);
        else pass_cnt++;
        op8(8'h12, 8'h34, 1'b0, lat, got);
        exp = sb.pop_front();
        total_cnt++;
        if (33'(got) !== exp || lat !== 8)
            $display("FAIL midreset_next: got %h lat %0d want %h lat 8", got, lat, exp);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int c1n, c2n;
        logic [32:0] exp;
        s8 = 1'b1; a8 = 8'h01; b8 = 8'h02; c8 = 1'b0;
        sb.push_back(33'd3);
        tick;
        a8 = 8'h03; b8 = 8'h04;
        sb.push_back(33'd7);
        c1n = 0;
        while (!done8 && c1n < 20) begin
            tick;
            c1n++;
        end
        exp = sb.pop_front();
        total_cnt++;
        if (33'({cout8, sum8}) !== exp || c1n !== 8)
            $display("FAIL b2b_first: got %h lat %0d want %h lat 8", {cout8, sum8}, c1n, exp);
        else pass_cnt++;
        tick;
        s8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        c2n = 1;
        while (!done8 && c2n < 20) begin
            tick;
            c2n++;
        end
        exp = sb.pop_front();
        total_cnt++;
        if (33'({cout8, sum8}) !== exp) $display("FAIL b2b_second: got %h want %h", {cout8, sum8}, exp);
        else pass_cnt++;
        total_cnt++;
        if (c2n !== 9) $display("FAIL b2b_spacing: got %0d want 9", c2n);
        else pass_cnt++;
    endtask

    task automatic test_random(input int w);
        logic [31:0] ra, rb, mask;
        logic        rc, bad;
        logic [32:0] exp, got;
        int          cyc;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        for (int n = 0; n < 1000; n++) begin
            ra = $urandom & mask;
            rb = $urandom & mask;
            rc = 1'($urandom_range(0, 1));
            set_in(w, 1'b1, ra, rb, rc);
            sb.push_back(33'(ra) + 33'(rb) + 33'(rc));
            tick;
            cyc = 0;
            bad = 1'b0;
            do begin
                // Noise on the inputs, including start, while the op is in flight.
                set_in(w, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)));
                tick;
                cyc++;
                if (get_done(w) && get_busy(w)) bad = 1'b1;
            end while (!get_done(w) && cyc < w + 4);
            set_in(w, 1'b0, 32'h0, 32'h0, 1'b0);
            got = get_res(w);
            exp = sb.pop_front();
            total_cnt++;
            if (got !== exp)
                $display("FAIL rand_w%0d_sum: op %0d got %h want %h", w, n, got, exp);
            else pass_cnt++;
            total_cnt++;
            if (cyc !== w || !get_done(w))
                $display("FAIL rand_w%0d_latency: op %0d got %0d want %0d", w, n, cyc, w);
            else pass_cnt++;
            tick;
            if (get_done(w) && get_busy(w)) bad = 1'b1;
            total_cnt++;
            if (get_done(w) !== 1'b0 || bad !== 1'b0)
                $display("FAIL rand_w%0d_pulse: op %0d got done=%b overlap=%b want 0 0",
                         w, n, get_done(w), bad);
            else pass_cnt++;
            if ($urandom_range(0, 1) == 1) tick;
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_carry;
        test_ignore;
        test_reset_mid;
        test_back_to_back;
        test_random(1);
        test_random(8);
        test_random(32);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_serial_adder
